// File: rtl/sys_uart_pkg.sv
// sys_uart_pkg -- definitions shared by the UART frame transmitter files.
//
// Contents:
//   DEFAULT_DATA_WIDTH : default payload bits per frame
//   tx_state_e         : transmitter FSM state encoding
//   cnt_width()        : width of a counter that indexes 0..w-1 (min 1 bit)
//
// Optional feature macro used by the files importing this package:
//   UART_TX_PARITY_EN  (parity state and parity calculation)

package sys_uart_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // A single-bit payload still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc -- parity bit for a latched UART payload.
//
// Ports:
//   data       in  [DATA_WIDTH-1:0]  payload the parity covers
//   odd        in  1                 0 = even parity, 1 = odd parity
//   parity_bit out 1                 bit placed on the line after the payload
//
// Optional feature macro: UART_TX_PARITY_EN. The module only exists in builds
// with that macro defined, because it is only instantiated there; this keeps
// parity-less builds free of an unreferenced module.

`ifdef UART_TX_PARITY_EN
module uart_tx_parity_calc
  import sys_uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  odd,
  output logic                  parity_bit
);

  // Even parity makes the total count of ones even: the bit equals the XOR
  // of the payload. Odd parity is its inverse.
  assign parity_bit = (^data) ^ odd;

endmodule
`endif

// File: rtl/uart_frame_tx.sv
// uart_frame_tx -- UART frame serializer, one line bit per CLK rising edge.
//
// Frame: start (0), DATA_WIDTH payload bits LSB first, optional parity bit,
// stop (1). The line idles high. A request is taken only while idle; requests
// arriving during a frame are dropped.
//
// Ports:
//   CLK        in  1                baud-rate clock
//   RST        in  1                asynchronous active-low reset
//   P_DATA     in  [DATA_WIDTH-1:0] payload, latched on the accept edge
//   DATA_VALID in  1                request strobe, honoured only while idle
//   PAR_EN     in  1                1 = insert a parity bit (latched on accept)
//   PAR_TYP    in  1                0 = even, 1 = odd (latched on accept)
//   TX_OUT     out 1                registered serial line, idle high
//   BUSY       out 1                registered, high while a frame is on the line
//
// Optional feature macro: UART_TX_PARITY_EN. When undefined, PAR_EN and
// PAR_TYP are accepted but ignored and every frame is DATA_WIDTH+2 bits.

module uart_frame_tx
  import sys_uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q;
  tx_state_e             state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  accept;
  logic                  use_parity;
  logic                  parity_bit;
  logic                  tx_d;
  logic                  busy_d;

  assign accept = (state_q == IDLE) && DATA_VALID;

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;

  // Frame options are captured with the payload so the frame in flight is
  // immune to later input changes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (accept) begin
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data       (data_q),
    .odd        (par_typ_q),
    .parity_bit (parity_bit)
  );

  assign use_parity = par_en_q;
`else
  logic unused_par_cfg;

  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
  assign use_parity     = 1'b0;
  assign parity_bit     = 1'b1;
`endif

  // Next state and the line value for the next state. TX_OUT and BUSY are
  // registered from these, so the outputs always describe the current state
  // and never depend combinationally on the inputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = use_parity ? PARITY : STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[cnt_d];
      PARITY:  tx_d = parity_bit;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      TX_OUT  <= 1'b1;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      TX_OUT  <= tx_d;
      BUSY    <= busy_d;
      if (accept) begin
        data_q <= P_DATA;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx -- self-checking bench for uart_frame_tx (DATA_WIDTH = 8).
// Directed frames come from a table of expected line sequences; a random
// phase compares every cycle against a frame-queue model of the line.

module tb_uart_frame_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  uart_frame_tx #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Line sequence: bits[len-1] is the first bit on the line (start bit).
  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic [10:0] bits;
    int          len;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b expected=%0b", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called right after the accept edge; checks every line bit of the frame,
  // leaving the DUT showing the stop bit. A stray 0x3C request can be pulsed
  // at frame position pulse_at.
  task automatic expect_frame(input vec_t v, input string nm, input int pulse_at);
    for (int i = 0; i < v.len; i++) begin
      if (i > 0) begin
        if (i == pulse_at) begin
          P_DATA     = 8'h3C;
          DATA_VALID = 1'b1;
        end
        tick();
        DATA_VALID = 1'b0;
      end
      chk($sformatf("%s tx[%0d]", nm, i), TX_OUT, v.bits[v.len-1-i]);
      chk($sformatf("%s busy[%0d]", nm, i), BUSY, 1'b1);
    end
  endtask

  task automatic start_req(input vec_t v);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
  endtask

  task automatic expect_idle(input string nm);
    chk({nm, " tx"}, TX_OUT, 1'b1);
    chk({nm, " busy"}, BUSY, 1'b0);
  endtask

  // Reference model: a queue of pending line bits built from the frame rules.
  logic m_q[$];
  logic m_busy;
  logic exp_tx;
  logic exp_busy;

  task automatic model_edge(input logic v, input logic [7:0] d, input logic pe, input logic pt);
    if (!m_busy && v) begin
      m_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) m_q.push_back(d[b]);
      if (PAR_BUILD && pe) m_q.push_back(logic'(($countones(d) % 2) == 1) ^ pt);
      m_q.push_back(1'b1);
    end
    if (m_q.size() > 0) begin
      exp_tx   = m_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    m_busy = exp_busy;
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{data: 8'hAA, pe: 1'b1, pt: 1'b0, bits: 11'b00101010101, len: 11};
    vecs[1] = '{data: 8'h05, pe: 1'b0, pt: 1'b0, bits: 11'b00101000001, len: 10};
    vecs[2] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, bits: 11'b01000000011, len: 11};
    vecs[3] = '{data: 8'h77, pe: 1'b1, pt: 1'b1, bits: 11'b01110111011, len: 11};
`else
    vecs[0] = '{data: 8'hAA, pe: 1'b1, pt: 1'b0, bits: 11'b00010101011, len: 10};
    vecs[1] = '{data: 8'h05, pe: 1'b0, pt: 1'b0, bits: 11'b00101000001, len: 10};
    vecs[2] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, bits: 11'b00100000001, len: 10};
    vecs[3] = '{data: 8'h77, pe: 1'b1, pt: 1'b1, bits: 11'b00111011101, len: 10};
`endif

    RST        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 RST = 1'b0;
    #1 expect_idle("reset async");
    tick();
    tick();
    expect_idle("reset held");

    // Release; the very first edge after release accepts a request.
    RST = 1'b1;
    foreach (vecs[k]) begin
      start_req(vecs[k]);
      expect_frame(vecs[k], $sformatf("vec%0d", k), -1);
      tick();
      expect_idle($sformatf("vec%0d after", k));
    end

    // Back-to-back: request held across the stop bit -> one idle bit, then
    // the second frame starts.
    start_req(vecs[2]);
    expect_frame(vecs[2], "b2b first", -1);
    P_DATA     = vecs[3].data;
    PAR_EN     = vecs[3].pe;
    PAR_TYP    = vecs[3].pt;
    DATA_VALID = 1'b1;
    tick();
    expect_idle("b2b gap");
    tick();
    DATA_VALID = 1'b0;
    expect_frame(vecs[3], "b2b second", -1);
    tick();
    expect_idle("b2b after");

    // Request pulsed mid-frame is dropped, not queued.
    start_req(vecs[0]);
    expect_frame(vecs[0], "drop", 4);
    tick();
    expect_idle("drop after1");
    tick();
    expect_idle("drop after2");

    // Reset in the middle of data bit 3 of a 0x00 frame.
    start_req('{data: 8'h00, pe: 1'b0, pt: 1'b0, bits: 11'b0, len: 10});
    for (int i = 0; i < 4; i++) tick();
    chk("midrst bit3 tx", TX_OUT, 1'b0);
    #2 RST = 1'b0;
    #1 expect_idle("midrst async");
    tick();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_idle($sformatf("midrst post%0d", i));
    end

    // Random traffic; inputs change every cycle, including mid-frame.
    m_q.delete();
    m_busy = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      model_edge(DATA_VALID, P_DATA, PAR_EN, PAR_TYP);
      tick();
      chk($sformatf("rand tx c%0d", c), TX_OUT, exp_tx);
      chk($sformatf("rand busy c%0d", c), BUSY, exp_busy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
